// File: rtl/matrix_result_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matrix_result_serializer_pkg
// Description : Shared constants, state encodings and index helpers for the
//               3x3 result serializer.
// Revision    : 1.0 - initial release
// ============================================================================
package matrix_result_serializer_pkg;

    localparam int         DW_DEFAULT = 16;
    localparam int         NUM_ELEM   = 9;
    localparam logic [3:0] LAST_IDX   = 4'd8;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    typedef struct packed {
        logic [1:0] row;
        logic [1:0] col;
    } rc_t;

    // Row-major flat index to (row, column) of the 3x3 result.
    function automatic rc_t idx_to_rc(input logic [3:0] idx);
        rc_t rc;
        rc = '0;
        case (idx)
            4'd0: begin rc.row = 2'd0; rc.col = 2'd0; end
            4'd1: begin rc.row = 2'd0; rc.col = 2'd1; end
            4'd2: begin rc.row = 2'd0; rc.col = 2'd2; end
            4'd3: begin rc.row = 2'd1; rc.col = 2'd0; end
            4'd4: begin rc.row = 2'd1; rc.col = 2'd1; end
            4'd5: begin rc.row = 2'd1; rc.col = 2'd2; end
            4'd6: begin rc.row = 2'd2; rc.col = 2'd0; end
            4'd7: begin rc.row = 2'd2; rc.col = 2'd1; end
            4'd8: begin rc.row = 2'd2; rc.col = 2'd2; end
            default: rc = '0;
        endcase
        return rc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_result_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : matrix_result_serializer_if
// Description : Valid/ready output stream carrying one result word per beat.
// Revision    : 1.0 - initial release
// ============================================================================
interface matrix_result_serializer_if #(
    parameter int DW = 16
);
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic [1:0]    m_row;
    logic [1:0]    m_col;
    logic          m_last;

    modport master (
        output m_data, m_valid, m_row, m_col, m_last,
        input  m_ready
    );

    modport slave (
        input  m_data, m_valid, m_row, m_col, m_last,
        output m_ready
    );
endinterface
`default_nettype wire

// File: rtl/matrix_result_serializer_result_buf9.sv
`default_nettype none
// ============================================================================
// Module      : result_buf9
// Description : Nine-entry register file with parallel load and registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module result_buf9
    import matrix_result_serializer_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  wire logic                         clk,
    input  wire logic                         rst,
    input  wire logic                         load_en,
    input  wire logic [NUM_ELEM-1:0][DW-1:0]  load_data,
    input  wire logic                         rd_en,
    input  wire logic [3:0]                   rd_idx,
    output logic      [DW-1:0]                rd_data
);

    logic [DW-1:0] r_mem [NUM_ELEM];
    logic [DW-1:0] r_rd_data;

    generate
        for (genvar gi = 0; gi < NUM_ELEM; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (load_en) begin
                    r_mem[gi] <= load_data[gi];
                end
            end
        end
    endgenerate

    // A read in the load cycle takes the incoming word so the first beat has no bubble.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_data <= '0;
        end else if (rd_en) begin
            r_rd_data <= load_en ? load_data[rd_idx] : r_mem[rd_idx];
        end
    end

    assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/matrix_result_serializer.sv
`default_nettype none
// ============================================================================
// Module      : matrix_result_serializer
// Description : Captures a 3x3 result frame on done_in and streams it row-major.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_result_serializer
    import matrix_result_serializer_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int CW = 8
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 done_in,
    input  wire logic [DW-1:0]        c11,
    input  wire logic [DW-1:0]        c12,
    input  wire logic [DW-1:0]        c13,
    input  wire logic [DW-1:0]        c21,
    input  wire logic [DW-1:0]        c22,
    input  wire logic [DW-1:0]        c23,
    input  wire logic [DW-1:0]        c31,
    input  wire logic [DW-1:0]        c32,
    input  wire logic [DW-1:0]        c33,
    matrix_result_serializer_if.master m_if,
    output logic                      busy,
    output logic                      drop_err,
    output logic      [CW-1:0]        frame_cnt
);

    logic [0:0]                  r_state;
    logic [0:0]                  w_state_nxt;
    logic [3:0]                  r_idx;
    logic [3:0]                  w_idx_nxt;
    logic                        w_hs;
    logic                        w_final_hs;
    logic                        w_accept;
    logic                        w_rd_en;
    logic                        r_last;
    rc_t                         r_rc;
    rc_t                         w_rc;
    logic [CW-1:0]               r_frame_cnt;
    logic                        r_drop_err;
    logic [DW-1:0]               w_rd_data;
    logic [NUM_ELEM-1:0][DW-1:0] w_load_data;

    assign w_load_data = {c33, c32, c31, c23, c22, c21, c13, c12, c11};

    // A done_in coinciding with the final handshake starts the next frame back-to-back.
    always_comb begin
        w_hs        = (r_state == S_SEND) && m_if.m_ready;
        w_final_hs  = w_hs && (r_idx == LAST_IDX);
        w_accept    = done_in && ((r_state == S_IDLE) || w_final_hs);
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        if (w_accept) begin
            w_state_nxt = S_SEND;
            w_idx_nxt   = 4'd0;
        end else if (w_final_hs) begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = 4'd0;
        end else if (w_hs) begin
            w_idx_nxt   = r_idx + 4'd1;
        end
        w_rd_en = w_accept || (w_hs && !w_final_hs);
        w_rc    = idx_to_rc(w_idx_nxt);
    end

    result_buf9 #(
        .DW (DW)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .load_en   (w_accept),
        .load_data (w_load_data),
        .rd_en     (w_rd_en),
        .rd_idx    (w_idx_nxt),
        .rd_data   (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_idx       <= 4'd0;
            r_last      <= 1'b0;
            r_rc        <= '0;
            r_frame_cnt <= '0;
            r_drop_err  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            if (w_rd_en) begin
                r_rc   <= w_rc;
                r_last <= (w_idx_nxt == LAST_IDX);
            end else if (w_final_hs) begin
                r_last <= 1'b0;
            end
            if (w_final_hs) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
            if (done_in && (r_state == S_SEND) && !w_final_hs) begin
                r_drop_err <= 1'b1;
            end
        end
    end

    assign m_if.m_data  = w_rd_data;
    assign m_if.m_valid = (r_state == S_SEND);
    assign m_if.m_row   = r_rc.row;
    assign m_if.m_col   = r_rc.col;
    assign m_if.m_last  = r_last;
    assign busy         = (r_state == S_SEND);
    assign drop_err     = r_drop_err;
    assign frame_cnt    = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_matrix_result_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_result_serializer
// Description : Directed self-checking bench for matrix_result_serializer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_result_serializer;

    localparam int DW = 16;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          done_in = 1'b0;
    logic [DW-1:0] c [9];
    logic          busy;
    logic          drop_err;
    logic [CW-1:0] frame_cnt;

    int passed = 0;
    int total  = 0;
    int exp_fc = 0;

    matrix_result_serializer_if #(.DW(DW)) bus ();

    matrix_result_serializer #(
        .DW (DW),
        .CW (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .done_in   (done_in),
        .c11       (c[0]),
        .c12       (c[1]),
        .c13       (c[2]),
        .c21       (c[3]),
        .c22       (c[4]),
        .c23       (c[5]),
        .c31       (c[6]),
        .c32       (c[7]),
        .c33       (c[8]),
        .m_if      (bus),
        .busy      (busy),
        .drop_err  (drop_err),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_c(input logic [DW-1:0] base, input bit down);
        for (int i = 0; i < 9; i++) begin
            c[i] = down ? base - DW'(i) : base + DW'(i);
        end
    endtask

    task automatic beat(input string tag, input int k, input logic [DW-1:0] d);
        chk({tag, "_valid"}, 32'(bus.m_valid), 32'd1);
        chk({tag, "_data"},  32'(bus.m_data),  32'(d));
        chk({tag, "_row"},   32'(bus.m_row),   32'(k / 3));
        chk({tag, "_col"},   32'(bus.m_col),   32'(k % 3));
        chk({tag, "_last"},  32'(bus.m_last),  32'(k == 8));
    endtask

    initial begin
        int e;
        int cyc;
        set_c('0, 1'b0);
        bus.m_ready = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_valid", 32'(bus.m_valid), 32'd0);
        chk("rst_data",  32'(bus.m_data),  32'd0);
        chk("rst_row",   32'(bus.m_row),   32'd0);
        chk("rst_col",   32'(bus.m_col),   32'd0);
        chk("rst_last",  32'(bus.m_last),  32'd0);
        chk("rst_busy",  32'(busy),        32'd0);
        chk("rst_drop",  32'(drop_err),    32'd0);
        chk("rst_fc",    32'(frame_cnt),   32'd0);
        rst = 1'b1;
        tick();
        chk("idle_valid", 32'(bus.m_valid), 32'd0);

        // Basic frame 1..9, inputs changed afterwards must not leak in
        set_c(16'd1, 1'b0);
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        set_c(16'h0A00, 1'b0);
        chk("t1_busy", 32'(busy), 32'd1);
        for (int k = 0; k < 9; k++) begin
            beat("t1", k, DW'(k + 1));
            tick();
        end
        exp_fc = 1;
        chk("t1_end_valid", 32'(bus.m_valid), 32'd0);
        chk("t1_end_busy",  32'(busy),        32'd0);
        chk("t1_end_fc",    32'(frame_cnt),   32'(exp_fc));

        // Backpressure with ready pattern 1,0,0 repeating
        set_c(16'd1, 1'b0);
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        e = 0;
        cyc = 0;
        while (e < 9 && cyc < 60) begin
            bus.m_ready = (cyc % 3 == 0);
            beat("t2", e, DW'(e + 1));
            tick();
            if (bus.m_ready) e++;
            cyc++;
        end
        bus.m_ready = 1'b1;
        exp_fc = 2;
        chk("t2_handshakes", 32'(e), 32'd9);
        chk("t2_end_valid",  32'(bus.m_valid), 32'd0);
        chk("t2_end_fc",     32'(frame_cnt),   32'(exp_fc));

        // Back-to-back frames: new done_in on the c33 handshake
        set_c(16'd1, 1'b0);
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        for (int k = 0; k < 9; k++) begin
            beat("t3a", k, DW'(k + 1));
            if (k == 8) begin
                set_c(16'hFFFF, 1'b1);
                done_in = 1'b1;
            end
            tick();
            done_in = 1'b0;
        end
        exp_fc = 3;
        chk("t3_fc_mid", 32'(frame_cnt), 32'(exp_fc));
        for (int k = 0; k < 9; k++) begin
            beat("t3b", k, 16'hFFFF - DW'(k));
            tick();
        end
        exp_fc = 4;
        chk("t3_end_valid", 32'(bus.m_valid), 32'd0);
        chk("t3_end_fc",    32'(frame_cnt),   32'(exp_fc));

        // done_in mid-frame at idx 4 is dropped and flagged
        set_c(16'd1, 1'b0);
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        for (int k = 0; k < 9; k++) begin
            beat("t4", k, DW'(k + 1));
            if (k == 4) begin
                set_c(16'd100, 1'b0);
                done_in = 1'b1;
            end
            tick();
            done_in = 1'b0;
            if (k == 4) chk("t4_drop_set", 32'(drop_err), 32'd1);
        end
        exp_fc = 5;
        chk("t4_drop_sticky", 32'(drop_err),    32'd1);
        chk("t4_end_valid",   32'(bus.m_valid), 32'd0);
        chk("t4_end_fc",      32'(frame_cnt),   32'(exp_fc));

        // Reset mid-frame at idx 5
        set_c(16'd1, 1'b0);
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
        end
        beat("t5_pre", 5, 16'd6);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        exp_fc = 0;
        chk("t5_valid", 32'(bus.m_valid), 32'd0);
        chk("t5_busy",  32'(busy),        32'd0);
        chk("t5_fc",    32'(frame_cnt),   32'(exp_fc));
        chk("t5_drop",  32'(drop_err),    32'd0);
        set_c(16'h0011, 1'b0);
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        for (int k = 0; k < 9; k++) begin
            beat("t5b", k, 16'h0011 + DW'(k));
            tick();
        end
        exp_fc = 1;
        chk("t5_end_fc", 32'(frame_cnt), 32'(exp_fc));

        // 256 back-to-back frames wrap the frame counter
        rst = 1'b0;
        tick();
        rst = 1'b1;
        set_c(16'd1, 1'b0);
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        for (int f = 0; f < 256; f++) begin
            repeat (8) tick();
            chk("t6_last", 32'(bus.m_last),  32'd1);
            chk("t6_fc",   32'(frame_cnt),   32'(f));
            done_in = (f < 255);
            tick();
            done_in = 1'b0;
        end
        chk("t6_wrap_fc",    32'(frame_cnt),   32'd0);
        chk("t6_end_valid",  32'(bus.m_valid), 32'd0);
        chk("t6_drop",       32'(drop_err),    32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
